dm_port_arbiter: RTL and testbench

Shares the single-port synchronous data memory between the CPU core's load/store port and a loader port used for bulk data initialisation and readback. It sits between `cpu_core`/loader and `data_mem`. It grants one requester per cycle, locks the memory to the loader for bursts, stalls the CPU when it loses a grant, and returns read data tagged to the requester that issued it (1-cycle memory read latency).

---
 rtl/dm_arb_pkg.sv | 17 +
 rtl/dm_arb_pick.sv | 43 ++++
 rtl/dm_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: FSM state and
// requester (owner) encodings plus the default loader burst length.
package dm_arb_pkg;

   typedef enum logic {
      ARB      = 1'b0,
      LD_BURST = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LD  = 1'b1
   } owner_e;

   localparam int unsigned DM_MAX_BURST = 16;

endpackage : dm_arb_pkg

// File: rtl/dm_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Optional feature macro: DM_ARB_RR_EN (round-robin conflict resolution
// in ARB); without it the CPU always wins conflicts in ARB.
module dm_arb_pick (
   input  logic cpu_req_i,
   input  logic ld_req_i,
   input  logic last_win_i,   // owner_e encoding
   input  logic state_i,      // arb_state_e encoding
   output logic cpu_gnt_o,
   output logic ld_gnt_o
);
   import dm_arb_pkg::*;

`ifndef DM_ARB_RR_EN
   // Fixed priority never looks at the previous winner.
   logic unused_last_win;
   assign unused_last_win = last_win_i;
`endif

   // One-hot grant from state and requests; the burst lock shuts the CPU out.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      cpu_gnt_o = 1'b0;
      ld_gnt_o  = 1'b0;
      if (state_i == LD_BURST) begin
         ld_gnt_o = ld_req_i;
      end else if (cpu_req_i && ld_req_i) begin
`ifdef DM_ARB_RR_EN
         if (last_win_i == OWN_LD) begin
            cpu_gnt_o = 1'b1;
         end else begin
            ld_gnt_o = 1'b1;
         end
`else
         cpu_gnt_o = 1'b1;
`endif
      end else begin
         cpu_gnt_o = cpu_req_i;
         ld_gnt_o  = ld_req_i;
      end
   end

endmodule : dm_arb_pick

// File: rtl/dm_port_arbiter.sv
// Shares the single-port synchronous data memory between the CPU load/store
// port and the bulk loader port. One grant per cycle, loader bursts lock the
// memory, read data (1-cycle latency) is tagged back to its requester.
// Optional feature macro: DM_ARB_RR_EN (see dm_arb_pick).
module dm_port_arbiter
   import dm_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_BURST = DM_MAX_BURST
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_din_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_dout_o,
   input  logic              ld_req_i,
   input  logic              ld_we_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_din_i,
   input  logic              ld_last_i,
   output logic              ld_gnt_o,
   output logic              ld_rvalid_o,
   output logic [DATA_W-1:0] ld_dout_o,
   output logic              dm_we_o,
   output logic [ADDR_W-1:0] dm_addr_o,
   output logic [DATA_W-1:0] dm_din_o,
   input  logic [DATA_W-1:0] dm_dout_i
);

   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   arb_state_e        state_q, state_d;
   owner_e            last_win_q, last_win_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              rd_cpu_q, rd_ld_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              cpu_gnt, ld_gnt;

   dm_arb_pick u_pick (
      .cpu_req_i  (cpu_req_i),
      .ld_req_i   (ld_req_i),
      .last_win_i (last_win_q),
      .state_i    (state_q),
      .cpu_gnt_o  (cpu_gnt),
      .ld_gnt_o   (ld_gnt)
   );

   assign cpu_gnt_o = cpu_gnt;
   assign ld_gnt_o  = ld_gnt;

   // Count saturates at MAX_BURST instead of wrapping.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

   // Next state: enter a burst on a non-final loader beat, leave on last beat,
   // on reaching MAX_BURST (forced release) or when the loader drops its request.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_win_d = last_win_q;
      unique case (state_q)
         ARB: begin
            if (cpu_gnt) last_win_d = OWN_CPU;
            if (ld_gnt)  last_win_d = OWN_LD;
            if (ld_gnt && !ld_last_i) begin
               state_d = LD_BURST;
               cnt_d   = CNT_ONE;
            end
         end
         LD_BURST: begin
            if (!ld_req_i) begin
               state_d = ARB;
               cnt_d   = '0;
            end else if (ld_last_i || (cnt_inc == CNT_MAX)) begin
               state_d    = ARB;
               cnt_d      = '0;
               last_win_d = OWN_LD;   // CPU takes the next conflict
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = ARB;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM, burst counter and round-robin history registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB;
         cnt_q      <= '0;
         last_win_q <= OWN_LD;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_win_q <= last_win_d;
      end
   end

   // Read tags and the last driven memory address/data, held while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cpu_q <= 1'b0;
         rd_ld_q  <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
      end else begin
         rd_cpu_q <= cpu_gnt && !cpu_we_i;
         rd_ld_q  <= ld_gnt && !ld_we_i;
         if (cpu_gnt) begin
            addr_q <= cpu_addr_i;
            din_q  <= cpu_din_i;
         end else if (ld_gnt) begin
            addr_q <= ld_addr_i;
            din_q  <= ld_din_i;
         end
      end
   end

   // Memory port mux: granted requester's fields, else hold the last value.
   always_comb begin
      dm_we_o   = 1'b0;
      dm_addr_o = addr_q;
      dm_din_o  = din_q;
      if (cpu_gnt) begin
         dm_we_o   = cpu_we_i;
         dm_addr_o = cpu_addr_i;
         dm_din_o  = cpu_din_i;
      end else if (ld_gnt) begin
         dm_we_o   = ld_we_i;
         dm_addr_o = ld_addr_i;
         dm_din_o  = ld_din_i;
      end
   end

   assign cpu_rvalid_o = rd_cpu_q;
   assign ld_rvalid_o  = rd_ld_q;
   assign cpu_dout_o   = dm_dout_i;
   assign ld_dout_o    = dm_dout_i;

endmodule : dm_port_arbiter

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter: directed scenarios plus random
// traffic, scored against a behavioural model of the arbitration rules and
// a reference copy of the memory contents.
// Honours DM_ARB_RR_EN the same way as the design.
module tb_dm_port_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 10;
   localparam int MAXB = 16;
   localparam int DEPTH = 1 << AW;
`ifdef DM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;
   logic          cpu_gnt_o, cpu_rvalid_o;
   logic [DW-1:0] cpu_dout_o;
   logic          ld_req = 1'b0, ld_we = 1'b0, ld_last = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_din = '0;
   logic          ld_gnt_o, ld_rvalid_o;
   logic [DW-1:0] ld_dout_o;
   logic          dm_we_o;
   logic [AW-1:0] dm_addr_o;
   logic [DW-1:0] dm_din_o;
   logic [DW-1:0] dm_dout;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   dm_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
      .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_dout_o(cpu_dout_o),
      .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_din_i(ld_din),
      .ld_last_i(ld_last), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o), .ld_dout_o(ld_dout_o),
      .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_din_o(dm_din_o), .dm_dout_i(dm_dout)
   );

   // Data memory: synchronous single port, one-cycle read latency.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];

   always @(posedge clk) begin
      if (dm_we_o) mem[dm_addr_o] <= dm_din_o;
      dm_dout <= mem[dm_addr_o];
   end

   // ---------------- reference model ----------------
   bit            mon_en = 1'b0;
   bit            m_locked;       // loader owns the memory
   int            m_beats;        // beats granted in the current burst
   bit            m_last_ld;      // most recent ARB winner was the loader
   logic [AW-1:0] m_hold_addr;
   logic [DW-1:0] m_hold_din;
   bit            x_rv_cpu, x_rv_ld;
   logic [DW-1:0] x_dat_cpu, x_dat_ld;
   bit            e_cpu, e_ld;

   task automatic model_reset();
      m_locked    = 1'b0;
      m_beats     = 0;
      m_last_ld   = 1'b1;
      m_hold_addr = '0;
      m_hold_din  = '0;
      x_rv_cpu    = 1'b0;
      x_rv_ld     = 1'b0;
   endtask

   // Monitor: compares every enabled cycle, then advances the model.
   always @(negedge clk) begin
      if (mon_en) begin
         e_cpu = 1'b0;
         e_ld  = 1'b0;
         if (m_locked) e_ld = ld_req;
         else if (cpu_req && ld_req) begin
            if (RR) begin
               e_cpu = m_last_ld;
               e_ld  = !m_last_ld;
            end else e_cpu = 1'b1;
         end else begin
            e_cpu = cpu_req;
            e_ld  = ld_req;
         end

         n_checks++;
         if (cpu_gnt_o !== e_cpu || ld_gnt_o !== e_ld)
            $display("FAIL mon_grant t=%0t got cpu=%b ld=%b expected cpu=%b ld=%b",
                     $time, cpu_gnt_o, ld_gnt_o, e_cpu, e_ld);
         else n_pass++;

         n_checks++;
         if (e_cpu) begin
            if (dm_we_o !== cpu_we || dm_addr_o !== cpu_addr || dm_din_o !== cpu_din)
               $display("FAIL mon_port_cpu t=%0t got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                        $time, dm_we_o, dm_addr_o, dm_din_o, cpu_we, cpu_addr, cpu_din);
            else n_pass++;
         end else if (e_ld) begin
            if (dm_we_o !== ld_we || dm_addr_o !== ld_addr || dm_din_o !== ld_din)
               $display("FAIL mon_port_ld t=%0t got we=%b a=%h d=%h expected we=%b a=%h d=%h",
                        $time, dm_we_o, dm_addr_o, dm_din_o, ld_we, ld_addr, ld_din);
            else n_pass++;
         end else begin
            if (dm_we_o !== 1'b0 || dm_addr_o !== m_hold_addr || dm_din_o !== m_hold_din)
               $display("FAIL mon_port_idle t=%0t got we=%b a=%h d=%h expected we=0 a=%h d=%h",
                        $time, dm_we_o, dm_addr_o, dm_din_o, m_hold_addr, m_hold_din);
            else n_pass++;
         end

         n_checks++;
         if (cpu_rvalid_o !== x_rv_cpu || ld_rvalid_o !== x_rv_ld)
            $display("FAIL mon_rvalid t=%0t got cpu=%b ld=%b expected cpu=%b ld=%b",
                     $time, cpu_rvalid_o, ld_rvalid_o, x_rv_cpu, x_rv_ld);
         else n_pass++;
         if (x_rv_cpu) begin
            n_checks++;
            if (cpu_dout_o !== x_dat_cpu)
               $display("FAIL mon_cpu_dout t=%0t got %h expected %h", $time, cpu_dout_o, x_dat_cpu);
            else n_pass++;
         end
         if (x_rv_ld) begin
            n_checks++;
            if (ld_dout_o !== x_dat_ld)
               $display("FAIL mon_ld_dout t=%0t got %h expected %h", $time, ld_dout_o, x_dat_ld);
            else n_pass++;
         end

         // Advance the model by one clock.
         x_rv_cpu = e_cpu && !cpu_we;
         x_rv_ld  = e_ld && !ld_we;
         if (e_cpu) begin
            x_dat_cpu   = ref_mem[cpu_addr];
            m_hold_addr = cpu_addr;
            m_hold_din  = cpu_din;
            if (cpu_we) ref_mem[cpu_addr] = cpu_din;
         end
         if (e_ld) begin
            x_dat_ld    = ref_mem[ld_addr];
            m_hold_addr = ld_addr;
            m_hold_din  = ld_din;
            if (ld_we) ref_mem[ld_addr] = ld_din;
         end
         if (!m_locked) begin
            if (e_cpu || e_ld) m_last_ld = e_ld;
            if (e_ld && !ld_last) begin
               m_locked = 1'b1;
               m_beats  = 1;
            end
         end else if (!ld_req) begin
            m_locked = 1'b0;
            m_beats  = 0;
         end else begin
            m_beats++;
            if (ld_last || m_beats >= MAXB) begin
               m_locked  = 1'b0;
               m_beats   = 0;
               m_last_ld = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0;
      ld_req  = 1'b0; ld_we  = 1'b0; ld_last = 1'b0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (cpu_gnt_o !== 1'b0 || ld_gnt_o !== 1'b0)
         $display("FAIL reset_grants got cpu=%b ld=%b expected 0 0", cpu_gnt_o, ld_gnt_o);
      else n_pass++;
      n_checks++;
      if (cpu_rvalid_o !== 1'b0 || ld_rvalid_o !== 1'b0)
         $display("FAIL reset_rvalid got cpu=%b ld=%b expected 0 0", cpu_rvalid_o, ld_rvalid_o);
      else n_pass++;
      n_checks++;
      if (dm_we_o !== 1'b0 || dm_addr_o !== '0 || dm_din_o !== '0)
         $display("FAIL reset_port got we=%b a=%h d=%h expected 0 0 0", dm_we_o, dm_addr_o, dm_din_o);
      else n_pass++;
      tick();
   endtask

   task automatic test_single_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
      @(negedge clk);
      n_checks++;
      if (cpu_gnt_o !== 1'b1) $display("FAIL single_gnt got %b expected 1", cpu_gnt_o);
      else n_pass++;
      tick();
      idle();
      @(negedge clk);
      n_checks++;
      if (cpu_rvalid_o !== 1'b1 || cpu_dout_o !== ref_mem[5])
         $display("FAIL single_rdata got v=%b d=%h expected v=1 d=%h", cpu_rvalid_o, cpu_dout_o, ref_mem[5]);
      else n_pass++;
      tick();
   endtask

   // Both request single-beat reads every cycle; previous winner was the CPU.
   task automatic test_conflict();
      bit x_ld;
      for (int i = 0; i < 8; i++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 63));
         ld_req  = 1'b1; ld_we  = 1'b0; ld_last = 1'b1; ld_addr = AW'($urandom_range(0, 63));
         x_ld = RR ? (i % 2 == 0) : 1'b0;
         @(negedge clk);
         n_checks++;
         if (ld_gnt_o !== x_ld || cpu_gnt_o !== !x_ld)
            $display("FAIL conflict_%0d got cpu=%b ld=%b expected cpu=%b ld=%b",
                     i, cpu_gnt_o, ld_gnt_o, !x_ld, x_ld);
         else n_pass++;
         tick();
      end
      idle();
      tick();
   endtask

   // 4-beat loader write burst with the CPU waiting, then loader readback.
   task automatic test_burst();
      logic [DW-1:0] wdat [4];
      for (int c = 0; c < 5; c++) begin
         cpu_req = (c >= 1); cpu_we = 1'b0; cpu_addr = 10'h050;
         ld_req  = (c < 4);  ld_we  = 1'b1; ld_addr = AW'(16 + c); ld_last = (c == 3);
         if (c < 4) begin
            wdat[c] = $urandom;
            ld_din  = wdat[c];
         end
         @(negedge clk);
         n_checks++;
         if (c < 4 && (ld_gnt_o !== 1'b1 || cpu_gnt_o !== 1'b0))
            $display("FAIL burst_beat_%0d got cpu=%b ld=%b expected cpu=0 ld=1", c, cpu_gnt_o, ld_gnt_o);
         else if (c == 4 && cpu_gnt_o !== 1'b1)
            $display("FAIL burst_cpu_after got %b expected 1", cpu_gnt_o);
         else n_pass++;
         tick();
      end
      idle();
      for (int c = 0; c < 5; c++) begin
         ld_req = (c < 4); ld_we = 1'b0; ld_last = 1'b1; ld_addr = AW'(16 + c);
         @(negedge clk);
         if (c > 0) begin
            n_checks++;
            if (ld_rvalid_o !== 1'b1 || ld_dout_o !== wdat[c-1])
               $display("FAIL burst_readback_%0d got v=%b d=%h expected v=1 d=%h",
                        c - 1, ld_rvalid_o, ld_dout_o, wdat[c-1]);
            else n_pass++;
         end
         tick();
      end
      idle();
   endtask

   // Loader never asserts last: lock released after MAXB beats.
   task automatic test_forced_release();
      for (int c = 0; c <= MAXB; c++) begin
         cpu_req = (c >= 1); cpu_we = 1'b0; cpu_addr = 10'h060;
         ld_req = 1'b1; ld_we = 1'b1; ld_last = 1'b0;
         ld_addr = AW'(256 + c); ld_din = $urandom;
         @(negedge clk);
         n_checks++;
         if (c < MAXB && (ld_gnt_o !== 1'b1 || cpu_gnt_o !== 1'b0))
            $display("FAIL forced_beat_%0d got cpu=%b ld=%b expected cpu=0 ld=1", c, cpu_gnt_o, ld_gnt_o);
         else if (c == MAXB && (cpu_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0))
            $display("FAIL forced_release got cpu=%b ld=%b expected cpu=1 ld=0", cpu_gnt_o, ld_gnt_o);
         else n_pass++;
         tick();
      end
      idle();
      tick();
   endtask

   task automatic test_raw();
      ld_req = 1'b1; ld_we = 1'b1; ld_last = 1'b1; ld_addr = 10'h020; ld_din = 32'hDEADBEEF;
      tick();
      idle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
      tick();
      idle();
      @(negedge clk);
      n_checks++;
      if (cpu_rvalid_o !== 1'b1 || cpu_dout_o !== 32'hDEADBEEF)
         $display("FAIL raw got v=%b d=%h expected v=1 d=deadbeef", cpu_rvalid_o, cpu_dout_o);
      else n_pass++;
      tick();
   endtask

   // Random traffic; each requester holds its fields until granted.
   task automatic test_random();
      bit cg = 1'b1, lg = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (!cpu_req || cg) begin
            cpu_req  = ($urandom_range(0, 2) != 0);
            cpu_we   = $urandom_range(0, 1);
            cpu_addr = AW'($urandom_range(0, 31));
            cpu_din  = $urandom;
         end
         if (!ld_req || lg) begin
            ld_req  = ($urandom_range(0, 4) != 0);
            ld_we   = $urandom_range(0, 1);
            ld_last = ($urandom_range(0, 3) == 0);
            ld_addr = AW'($urandom_range(0, 31));
            ld_din  = $urandom;
         end
         @(negedge clk);
         cg = cpu_gnt_o;
         lg = ld_gnt_o;
         tick();
      end
      idle();
      tick();
   endtask

   // Reset hits while a loader read is in flight inside a burst.
   task automatic test_reset_mid_burst();
      ld_req = 1'b1; ld_we = 1'b0; ld_last = 1'b0; ld_addr = 10'h030;
      tick();
      ld_addr = 10'h031;
      @(negedge clk);
      n_checks++;
      if (ld_gnt_o !== 1'b1) $display("FAIL rst_burst_gnt got %b expected 1", ld_gnt_o);
      else n_pass++;
      @(posedge clk);
      mon_en = 1'b0;
      idle();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ld_rvalid_o !== 1'b0 || cpu_rvalid_o !== 1'b0)
         $display("FAIL rst_rvalid got ld=%b cpu=%b expected 0 0", ld_rvalid_o, cpu_rvalid_o);
      else n_pass++;
      n_checks++;
      if (dm_we_o !== 1'b0 || dm_addr_o !== '0 || dm_din_o !== '0 || cpu_gnt_o !== 1'b0 || ld_gnt_o !== 1'b0)
         $display("FAIL rst_outputs got we=%b a=%h d=%h gc=%b gl=%b expected all 0",
                  dm_we_o, dm_addr_o, dm_din_o, cpu_gnt_o, ld_gnt_o);
      else n_pass++;
      @(posedge clk);
      model_reset();
      #1 rst_n = 1'b1;
      mon_en = 1'b1;
      // Back in ARB: a conflict now goes to the CPU in both configurations.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h031;
      ld_req  = 1'b1; ld_we  = 1'b0; ld_last = 1'b1; ld_addr = 10'h032;
      @(negedge clk);
      n_checks++;
      if (cpu_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0)
         $display("FAIL rst_state_arb got cpu=%b ld=%b expected cpu=1 ld=0", cpu_gnt_o, ld_gnt_o);
      else n_pass++;
      tick();
      idle();
      tick();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         logic [DW-1:0] v;
         v = $urandom;
         mem[i]     <= v;
         ref_mem[i] = v;
      end
      do_reset();
      test_reset();
      test_single_read();
      test_conflict();
      test_burst();
      test_forced_release();
      test_raw();
      test_random();
      test_reset_mid_burst();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_dm_port_arbiter
